pixel_history_buffer: RTL and testbench

PIXEL_HISTORY_BUFFER -- requirements
Module: pixel_history_buffer

---
 rtl/pixel_history_buffer_pkg.sv | 19 +
 rtl/pixel_history_buffer_history_ram.sv | 28 ++
 rtl/pixel_history_buffer.sv | 176 +++++++++++++++++
 tb/tb_pixel_history_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_history_buffer_pkg.sv
// Shared video constants, state encoding and range helper for the pixel history buffer.
package pixel_history_buffer_pkg;

   localparam int PHB_WIDTH  = 640;
   localparam int PHB_HEIGHT = 480;
   localparam int PHB_X_BITS = 10;
   localparam int PHB_Y_BITS = 9;
   localparam int PHB_DATA_W = 4;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } phb_state_e;

   function automatic logic in_frame(input int x, input int y, input int width, input int height);
      return (x < width) && (y < height);
   endfunction

endpackage

// File: rtl/pixel_history_buffer_history_ram.sv
// Dual-port history RAM: both ports can write, port A has a 1-cycle registered read.
module history_ram
   import pixel_history_buffer_pkg::*;
#(
   parameter int ADDR_W = PHB_X_BITS + PHB_Y_BITS,
   parameter int DATA_W = PHB_DATA_W
) (
   input  logic              clk,
   input  logic              a_we_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [DATA_W-1:0] a_wdata_i,
   output logic [DATA_W-1:0] a_rdata_o,
   input  logic              b_we_i,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [DATA_W-1:0] b_wdata_i
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // NOTE: the array and its read register carry no reset, so the storage maps onto block RAM;
   // contents are defined by the clear sweep that always follows reset.
   always_ff @(posedge clk) begin
      if (a_we_i) mem[a_addr_i] <= a_wdata_i;
      if (b_we_i) mem[b_addr_i] <= b_wdata_i;
      a_rdata_o <= mem[a_addr_i];
   end

endmodule

// File: rtl/pixel_history_buffer.sv
// Per-pixel history store with a runtime clear sweep, 2-cycle reads and write-first forwarding.
module pixel_history_buffer
   import pixel_history_buffer_pkg::*;
#(
   parameter int                WIDTH     = PHB_WIDTH,
   parameter int                HEIGHT    = PHB_HEIGHT,
   parameter int                X_BITS    = PHB_X_BITS,
   parameter int                Y_BITS    = PHB_Y_BITS,
   parameter int                DATA_W    = PHB_DATA_W,
   parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_req,
   output logic              busy,
   input  logic              rd_en,
   input  logic [X_BITS-1:0] rd_x,
   input  logic [Y_BITS-1:0] rd_y,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [X_BITS-1:0] rd_x_out,
   output logic [Y_BITS-1:0] rd_y_out,
   output logic              rd_oob,
   input  logic              wr_en,
   input  logic [X_BITS-1:0] wr_x,
   input  logic [Y_BITS-1:0] wr_y,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int                ADDR_W = X_BITS + Y_BITS;
   localparam logic [X_BITS-1:0] X_LAST = X_BITS'(WIDTH - 1);
   localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(HEIGHT - 2);

   typedef struct packed {
      logic              valid;
      logic [X_BITS-1:0] x;
      logic [Y_BITS-1:0] y;
      logic [DATA_W-1:0] data;
   } wr_req_t;

   typedef struct packed {
      logic              valid;
      logic              oob;
      logic              hit;
      logic [X_BITS-1:0] x;
      logic [Y_BITS-1:0] y;
      logic [DATA_W-1:0] fwd;
   } rd_req_t;

   phb_state_e        state_q;
   logic [X_BITS-1:0] clr_x_q;
   logic [Y_BITS-1:0] clr_y_q;
   logic              busy_q;

   wr_req_t           wr_d, wr_q;
   rd_req_t           rd_s1_d, rd_s1_q;

   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_d, rd_data_q;
   logic [X_BITS-1:0] rd_x_out_q;
   logic [Y_BITS-1:0] rd_y_out_q;
   logic              rd_oob_q;

   logic              clearing;
   logic              rd_acc, wr_acc;
   logic [DATA_W-1:0] ram_rdata;

   // Sweep walks y in pairs inside each column; clear_req always restarts it from (0,0).
   // NOTE: every register here uses <= so all flops see pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin : fsm
      if (!reset) begin
         state_q <= ST_CLEAR;
         clr_x_q <= '0;
         clr_y_q <= '0;
         busy_q  <= 1'b1;
      end else if (clear_req) begin
         state_q <= ST_CLEAR;
         clr_x_q <= '0;
         clr_y_q <= '0;
         busy_q  <= 1'b1;
      end else if (state_q == ST_CLEAR) begin
         if (clr_y_q == Y_LAST) begin
            clr_y_q <= '0;
            if (clr_x_q == X_LAST) begin
               state_q <= ST_RUN;
               busy_q  <= 1'b0;
               clr_x_q <= '0;
            end else begin
               clr_x_q <= clr_x_q + X_BITS'(1);
            end
         end else begin
            clr_y_q <= clr_y_q + Y_BITS'(2);
         end
      end
   end

   assign clearing = (state_q == ST_CLEAR);
   assign rd_acc   = rd_en && !busy_q;
   assign wr_acc   = wr_en && !busy_q && in_frame(int'(wr_x), int'(wr_y), WIDTH, HEIGHT);

   // The RAM read launched this cycle misses both the write retiring from wr_q and the one
   // being sampled now, so both are checked here; the incoming write is the newer one.
   // NOTE: each always_comb output gets a full default first so no path can infer a latch.
   always_comb begin
      wr_d       = '0;
      wr_d.valid = wr_acc;
      wr_d.x     = wr_x;
      wr_d.y     = wr_y;
      wr_d.data  = wr_data;

      rd_s1_d       = '0;
      rd_s1_d.valid = rd_acc;
      rd_s1_d.oob   = !in_frame(int'(rd_x), int'(rd_y), WIDTH, HEIGHT);
      rd_s1_d.x     = rd_x;
      rd_s1_d.y     = rd_y;
      if (wr_acc && wr_x == rd_x && wr_y == rd_y) begin
         rd_s1_d.hit = 1'b1;
         rd_s1_d.fwd = wr_data;
      end else if (wr_q.valid && wr_q.x == rd_x && wr_q.y == rd_y) begin
         rd_s1_d.hit = 1'b1;
         rd_s1_d.fwd = wr_q.data;
      end
   end

   always_comb begin
      rd_data_d = ram_rdata;
      if (rd_s1_q.oob)      rd_data_d = CLR_VALUE;
      else if (rd_s1_q.hit) rd_data_d = rd_s1_q.fwd;
   end

   always_ff @(posedge clk or negedge reset) begin : pipe
      if (!reset) begin
         wr_q       <= '0;
         rd_s1_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_x_out_q <= '0;
         rd_y_out_q <= '0;
         rd_oob_q   <= 1'b0;
      end else begin
         wr_q       <= wr_d;
         rd_s1_q    <= rd_s1_d;
         rd_valid_q <= rd_s1_q.valid;
         if (rd_s1_q.valid) begin
            rd_data_q  <= rd_data_d;
            rd_x_out_q <= rd_s1_q.x;
            rd_y_out_q <= rd_s1_q.y;
            rd_oob_q   <= rd_s1_q.oob;
         end
      end
   end

   // While clearing, both ports write the current column pair and any pending write is dropped:
   // it was sampled before the clear and would be overwritten anyway.
   history_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk       (clk),
      .a_we_i    (clearing),
      .a_addr_i  (clearing ? {clr_x_q, clr_y_q} : {rd_x, rd_y}),
      .a_wdata_i (CLR_VALUE),
      .a_rdata_o (ram_rdata),
      .b_we_i    (clearing || wr_q.valid),
      .b_addr_i  (clearing ? {clr_x_q, clr_y_q + Y_BITS'(1)} : {wr_q.x, wr_q.y}),
      .b_wdata_i (clearing ? CLR_VALUE : wr_q.data)
   );

   assign busy     = busy_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign rd_x_out = rd_x_out_q;
   assign rd_y_out = rd_y_out_q;
   assign rd_oob   = rd_oob_q;

endmodule

// File: tb/tb_pixel_history_buffer.sv
// Scoreboard bench for pixel_history_buffer on an 8x4 frame with 4-bit columns so x>=8 is reachable.
module tb_pixel_history_buffer;

   localparam int XB = 4;
   localparam int YB = 2;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          clear_req = 1'b0;
   logic          busy;
   logic          rd_en = 1'b0;
   logic [XB-1:0] rd_x = '0;
   logic [YB-1:0] rd_y = '0;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic [XB-1:0] rd_x_out;
   logic [YB-1:0] rd_y_out;
   logic          rd_oob;
   logic          wr_en = 1'b0;
   logic [XB-1:0] wr_x = '0;
   logic [YB-1:0] wr_y = '0;
   logic [DW-1:0] wr_data = '0;

   always #5 clk = ~clk;

   pixel_history_buffer #(
      .WIDTH     (8),
      .HEIGHT    (4),
      .X_BITS    (XB),
      .Y_BITS    (YB),
      .DATA_W    (DW),
      .CLR_VALUE (4'h5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clear_req (clear_req),
      .busy      (busy),
      .rd_en     (rd_en),
      .rd_x      (rd_x),
      .rd_y      (rd_y),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_x_out  (rd_x_out),
      .rd_y_out  (rd_y_out),
      .rd_oob    (rd_oob),
      .wr_en     (wr_en),
      .wr_x      (wr_x),
      .wr_y      (wr_y),
      .wr_data   (wr_data)
   );

   typedef struct {
      logic [10:0] resp;   // {oob, x, y, data}
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   pushes = 0;
   int   strobes = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset && rd_valid) begin
         strobes++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rd_unexpected: strobe x=%0d y=%0d with no read outstanding (cycle %0d)",
                     rd_x_out, rd_y_out, cyc);
         end else begin
            e = exp_q.pop_front();
            check("rd_resp", {21'd0, rd_oob, rd_x_out, rd_y_out, rd_data}, {21'd0, e.resp});
            check("rd_latency", cyc, e.cyc);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      clear_req = 1'b0;
   endtask

   // Read issued in this cycle is sampled on the next edge and must strobe two edges later.
   task automatic drv_rd(input int x, input int y, input logic [3:0] d, input logic oob);
      exp_t e;
      rd_en  = 1'b1;
      rd_x   = XB'(x);
      rd_y   = YB'(y);
      e.resp = {oob, 4'(x), 2'(y), d};
      e.cyc  = cyc + 2;
      exp_q.push_back(e);
      pushes++;
   endtask

   task automatic drv_wr(input int x, input int y, input logic [3:0] d);
      wr_en   = 1'b1;
      wr_x    = XB'(x);
      wr_y    = YB'(y);
      wr_data = d;
   endtask

   task automatic read_all(input logic [3:0] d);
      for (int x = 0; x < 8; x++)
         for (int y = 0; y < 4; y++) begin
            drv_rd(x, y, d, 1'b0);
            tick();
         end
   endtask

   task automatic count_busy(input int limit, output int n);
      n = 0;
      while (busy && n < limit) begin
         n++;
         tick();
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_busy"},     32'(busy),     32'd1);
      check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
      check({tag, "_rd_data"},  32'(rd_data),  32'd0);
      check({tag, "_rd_x_out"}, 32'(rd_x_out), 32'd0);
      check({tag, "_rd_y_out"}, 32'(rd_y_out), 32'd0);
      check({tag, "_rd_oob"},   32'(rd_oob),   32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin : stim
      int n;

      // Power-on reset, then a full 8*4/2 = 16 cycle sweep.
      repeat (3) @(negedge clk);
      check_reset_outs("por");
      reset = 1'b1;
      count_busy(100, n);
      check("por_busy_len", n, 16);

      // Every pixel reads the clear value, one read per cycle with no bubbles.
      read_all(4'h5);
      repeat (4) tick();
      check("b2b_strobes", strobes, 32);

      // Write-first coherence: next-cycle read, same-cycle read, newest-of-two wins.
      drv_wr(3, 2, 4'hA); tick();
      drv_rd(3, 2, 4'hA, 1'b0); tick();
      drv_wr(1, 1, 4'hA); drv_rd(1, 1, 4'hA, 1'b0); tick();
      drv_wr(2, 2, 4'h3); tick();
      drv_wr(2, 2, 4'h7); drv_rd(2, 2, 4'h7, 1'b0); tick();
      drv_rd(2, 2, 4'h7, 1'b0); tick();
      tick();
      drv_rd(3, 2, 4'hA, 1'b0); tick();
      drv_rd(1, 1, 4'hA, 1'b0); tick();
      drv_rd(2, 2, 4'h7, 1'b0); tick();
      drv_rd(3, 3, 4'h5, 1'b0); tick();

      // Out-of-range write is dropped; out-of-range reads return the clear value flagged oob.
      drv_wr(9, 1, 4'hC); tick();
      drv_rd(9, 1, 4'h5, 1'b1); tick();
      drv_rd(8, 0, 4'h5, 1'b1); tick();
      drv_rd(7, 3, 4'h5, 1'b0); tick();
      repeat (4) tick();

      // Fill with F, then clear and restart the clear in the 5th busy cycle: 5 + 16 busy cycles.
      for (int x = 0; x < 8; x++)
         for (int y = 0; y < 4; y++) begin
            drv_wr(x, y, 4'hF);
            tick();
         end
      drv_rd(5, 1, 4'hF, 1'b0); tick();
      drv_rd(0, 0, 4'hF, 1'b0); tick();
      repeat (4) tick();

      clear_req = 1'b1;
      tick();
      n = 0;
      while (busy && n < 100) begin
         n++;
         if (n == 2 || n == 3) begin
            rd_en = 1'b1;
            rd_x  = 4'd2;
            rd_y  = 2'd2;
         end
         if (n == 5)  clear_req = 1'b1;
         if (n == 21) drv_wr(0, 0, 4'hF);
         tick();
      end
      check("restart_busy_len", n, 21);
      read_all(4'h5);
      drv_rd(9, 1, 4'h5, 1'b1); tick();
      repeat (4) tick();
      check("strobes_vs_reads", strobes, pushes);

      // Reset in the middle of a sweep: outputs drop at once, then a full sweep follows.
      clear_req = 1'b1;
      tick();
      n = 0;
      while (busy && n < 7) begin
         n++;
         tick();
      end
      check("mid_sweep_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check_reset_outs("async");
      exp_q.delete();
      repeat (2) @(negedge clk);
      check_reset_outs("held");
      reset = 1'b1;
      count_busy(100, n);
      check("post_reset_busy_len", n, 16);
      drv_rd(3, 2, 4'h5, 1'b0); tick();
      drv_rd(7, 3, 4'h5, 1'b0); tick();
      repeat (4) tick();

      check("sb_empty", exp_q.size(), 0);
      check("strobes_vs_reads_final", strobes, pushes);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
